// File: rtl/hilo_ctrl.sv
// hilo_ctrl
//   Owns the HI/LO architectural registers and sequences the external
//   pipelined multiplier and iterative divider for MULT/MULTU/DIV/DIVU,
//   plus direct MTHI/MTLO writes. An exception flush (cancel) aborts an
//   in-flight operation without touching HI/LO.
//
// Ports
//   clk, resetn                  clock, synchronous active-low reset
//   op_valid/op_type/op_a/op_b   operation request (accepted on op_valid && op_ready)
//   op_ready                     IDLE and not being flushed
//   cancel                       exception flush, highest priority
//   mul_start/mul_signed/mul_a/mul_b    registered multiplier request
//   mul_result                   {hi, lo} product, valid MUL_LAT cycles after mul_start
//   div_start/div_signed/div_dividend/div_divisor  registered divider request
//   div_cancel                   one-cycle abort pulse to the divider
//   div_complete/div_quotient/div_remainder        divider result
//   hi, lo                       architectural HI/LO
//   busy                         a multiply or divide is in flight
module hilo_ctrl #(
  parameter int MUL_LAT = 2  // legal range 1..15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op_type,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        op_ready,
  input  logic        cancel,
  output logic        mul_start,
  output logic        mul_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_cancel,
  input  logic        div_complete,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_t;

  localparam logic [3:0] MUL_LAT_C = 4'(MUL_LAT);

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;

  logic accept;
  logic take_mul, take_div;   // launch a multiply / divide at this edge
  logic wr_mul, wr_div;       // retire a result into HI/LO at this edge
  logic wr_hi_op, wr_lo_op;   // MTHI / MTLO at this edge
  logic abort_div;            // flush while the divider is running

  assign op_ready = (state == IDLE) && !cancel;
  assign busy     = (state != IDLE);
  assign accept   = op_valid && op_ready;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    take_mul   = 1'b0;
    take_div   = 1'b0;
    wr_mul     = 1'b0;
    wr_div     = 1'b0;
    wr_hi_op   = 1'b0;
    wr_lo_op   = 1'b0;
    abort_div  = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          case (op_type)
            OP_MULT, OP_MULTU: begin
              take_mul   = 1'b1;
              cnt_next   = 4'd0;
              state_next = MUL_RUN;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero is architecturally undefined: keep HI/LO
              // and never wake the divider.
              if (op_b != '0) begin
                take_div   = 1'b1;
                state_next = DIV_RUN;
              end
            end
            OP_MTHI: wr_hi_op = 1'b1;
            OP_MTLO: wr_lo_op = 1'b1;
            default: ;  // reserved codes are accepted and dropped
          endcase
        end
      end

      MUL_RUN: begin
        if (cancel) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else if (cnt == MUL_LAT_C) begin
          wr_mul     = 1'b1;
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end

      DIV_RUN: begin
        if (cancel) begin
          abort_div  = 1'b1;
          state_next = IDLE;
        end else if (div_complete && !div_start) begin
          // A completion seen in the start cycle belongs to no request of
          // ours, so only later pulses retire the divide.
          wr_div     = 1'b1;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mul_start    <= 1'b0;
      mul_signed   <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      div_start    <= 1'b0;
      div_signed   <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      div_cancel   <= 1'b0;
      hi           <= '0;
      lo           <= '0;
    end else begin
      // Start pulses are registered from the acceptance decision, so they
      // occupy exactly the first cycle of the run state.
      mul_start  <= take_mul;
      div_start  <= take_div;
      div_cancel <= abort_div;

      if (take_mul) begin
        mul_a      <= op_a;
        mul_b      <= op_b;
        mul_signed <= (op_type == OP_MULT);
      end

      if (take_div) begin
        div_dividend <= op_a;
        div_divisor  <= op_b;
        div_signed   <= (op_type == OP_DIV);
      end

      // Result writes and MTHI/MTLO are mutually exclusive by state.
      if (wr_mul) begin
        hi <= mul_result[63:32];
        lo <= mul_result[31:0];
      end else if (wr_div) begin
        hi <= div_remainder;
        lo <= div_quotient;
      end else begin
        if (wr_hi_op) hi <= op_a;
        if (wr_lo_op) lo <= op_a;
      end
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// job-level reference model. The bench also plays the external multiplier
// and divider.
module tb_hilo_ctrl;

  localparam int MUL_LAT  = 2;
  localparam int JOB_NONE = 0;
  localparam int JOB_MUL  = 1;
  localparam int JOB_DIV  = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic [2:0]  op_type;
  logic [31:0] op_a, op_b;
  logic        op_ready;
  logic        cancel;
  logic        mul_start, mul_signed;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_result;
  logic        div_start, div_signed;
  logic [31:0] div_dividend, div_divisor;
  logic        div_cancel;
  logic        div_complete;
  logic [31:0] div_quotient, div_remainder;
  logic [31:0] hi, lo;
  logic        busy;

  always #5 clk = ~clk;

  hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .op_valid     (op_valid),
    .op_type      (op_type),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_ready     (op_ready),
    .cancel       (cancel),
    .mul_start    (mul_start),
    .mul_signed   (mul_signed),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_result   (mul_result),
    .div_start    (div_start),
    .div_signed   (div_signed),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_cancel   (div_cancel),
    .div_complete (div_complete),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder),
    .hi           (hi),
    .lo           (lo),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- arithmetic reference ----------------
  function automatic logic [63:0] product(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Returns {remainder, quotient}; 64-bit signed math avoids the
  // 0x80000000 / -1 overflow corner.
  function automatic logic [63:0] divide(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sb, q, r;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // ---------------- job-level reference model ----------------
  int          m_job = JOB_NONE;
  int          m_start = -10;      // cycle carrying the start pulse
  int          m_cancel_cyc = -1;  // cycle in which div_cancel must be high
  logic [63:0] m_result = '0;      // {hi, lo} the pending job will write
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [31:0] m_mul_a = '0, m_mul_b = '0, m_div_a = '0, m_div_b = '0;
  logic        m_mul_s = 1'b0, m_div_s = 1'b0;

  always @(posedge clk) begin
    if (!resetn) begin
      m_job = JOB_NONE; m_cancel_cyc = -1;
      m_hi = '0; m_lo = '0;
      m_mul_a = '0; m_mul_b = '0; m_mul_s = 1'b0;
      m_div_a = '0; m_div_b = '0; m_div_s = 1'b0;
    end else if (m_job == JOB_NONE) begin
      if (op_valid && !cancel) begin
        case (op_type)
          3'd0, 3'd1: begin
            m_job = JOB_MUL; m_start = cyc + 1;
            m_mul_a = op_a; m_mul_b = op_b; m_mul_s = (op_type == 3'd0);
            m_result = product(op_a, op_b, op_type == 3'd0);
          end
          3'd2, 3'd3: if (op_b != 0) begin
            m_job = JOB_DIV; m_start = cyc + 1;
            m_div_a = op_a; m_div_b = op_b; m_div_s = (op_type == 3'd2);
            m_result = divide(op_a, op_b, op_type == 3'd2);
          end
          3'd4: m_hi = op_a;
          3'd5: m_lo = op_a;
          default: ;
        endcase
      end
    end else if (cancel) begin
      if (m_job == JOB_DIV) m_cancel_cyc = cyc + 1;
      m_job = JOB_NONE;
    end else if (m_job == JOB_MUL && cyc == m_start + MUL_LAT) begin
      {m_hi, m_lo} = m_result;
      m_job = JOB_NONE;
    end else if (m_job == JOB_DIV && cyc > m_start && div_complete) begin
      {m_hi, m_lo} = m_result;
      m_job = JOB_NONE;
    end
    cyc++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      check("busy",         busy,        m_job != JOB_NONE);
      check("op_ready",     op_ready,    m_job == JOB_NONE && !cancel);
      check("ready_busy_excl", busy & op_ready, 1'b0);
      check("mul_start",    mul_start,   m_job == JOB_MUL && cyc == m_start);
      check("div_start",    div_start,   m_job == JOB_DIV && cyc == m_start);
      check("div_cancel",   div_cancel,  cyc == m_cancel_cyc);
      check("hi",           hi,          m_hi);
      check("lo",           lo,          m_lo);
      check("mul_a",        mul_a,       m_mul_a);
      check("mul_b",        mul_b,       m_mul_b);
      check("mul_signed",   mul_signed,  m_mul_s);
      check("div_dividend", div_dividend, m_div_a);
      check("div_divisor",  div_divisor, m_div_b);
      check("div_signed",   div_signed,  m_div_s);
    end
  end

  // ---------------- external multiplier / divider ----------------
  typedef struct {
    int          due;
    logic [63:0] val;
  } mul_entry_t;

  mul_entry_t  mq[$];
  int          dv_due = -1;
  logic [63:0] dv_res = '0;
  int          force_lat = 0;   // 0: random divider latency
  bit          force_spur = 1'b0;
  bit          rst_seen;

  always @(posedge clk) begin
    rst_seen = !resetn;
    #1;
    if (rst_seen || div_cancel) dv_due = -1;
    if (div_start) begin
      dv_res = divide(div_dividend, div_divisor, div_signed);
      dv_due = cyc + ((force_lat > 0) ? force_lat : int'($urandom_range(40, 1)));
    end
    if (mul_start) mq.push_back('{due: cyc + MUL_LAT, val: product(mul_a, mul_b, mul_signed)});
    while (mq.size() > 0 && mq[0].due < cyc) void'(mq.pop_front());

    mul_result = {$urandom, $urandom};
    foreach (mq[i]) if (mq[i].due == cyc) mul_result = mq[i].val;

    div_complete  = 1'b0;
    div_quotient  = $urandom;
    div_remainder = $urandom;
    if (cyc == dv_due) begin
      div_complete = 1'b1;
      {div_remainder, div_quotient} = dv_res;
      dv_due = -1;
    end else if (div_start && (force_spur || $urandom_range(2, 0) == 0)) begin
      div_complete = 1'b1;  // stray pulse with junk data in the start cycle
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op_type  = t;
    op_a     = a;
    op_b     = b;
  endtask

  task automatic idle_in();
    op_valid = 1'b0;
  endtask

  int t1, ready_at;
  bit done;

  initial begin
    mul_result = '0; div_complete = 1'b0; div_quotient = '0; div_remainder = '0;
    resetn = 1'b0; cancel = 1'b0;
    drive_op(3'd4, 32'h1234, 32'h0);

    // Reset held two edges with an MTHI pending.
    tick();
    check_en = 1'b1;
    tick();
    resetn = 1'b1;
    @(negedge clk);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_mul_a", mul_a, 32'h0);
    tick();
    idle_in();
    @(negedge clk);
    check("mthi_after_rst", hi, 32'h0000_1234);
    tick();

    // Signed multiply -2 * 3.
    drive_op(3'd0, 32'hFFFF_FFFE, 32'd3);
    tick();
    idle_in();
    for (int k = 0; k <= MUL_LAT + 1; k++) begin
      @(negedge clk);
      check("mult_start", mul_start, k == 0);
      check("mult_busy", busy, k <= MUL_LAT);
      if (k == 0) check("mult_signed", mul_signed, 1'b1);
      if (k == MUL_LAT + 1) begin
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);
      end
      tick();
    end

    // Unsigned divide 100 / 7, completion 33 cycles after start, stray pulse.
    force_lat = 33; force_spur = 1'b1;
    drive_op(3'd3, 32'd100, 32'd7);
    tick();
    idle_in();
    @(negedge clk);
    check("divu_start", div_start, 1'b1);
    check("divu_signed", div_signed, 1'b0);
    tick();
    @(negedge clk);
    check("divu_spurious_ignored", busy, 1'b1);
    repeat (32) tick();
    @(negedge clk);
    check("divu_still_busy", busy, 1'b1);
    tick();
    @(negedge clk);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    check("divu_ready", op_ready, 1'b1);
    tick();
    force_lat = 0; force_spur = 1'b0;

    // Divide by zero leaves HI/LO alone and never starts the divider.
    drive_op(3'd4, 32'd5, 32'd0);
    tick();
    drive_op(3'd5, 32'd6, 32'd0);
    tick();
    drive_op(3'd2, 32'd50, 32'd0);
    tick();
    idle_in();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("dz_busy", busy, 1'b0);
      check("dz_div_start", div_start, 1'b0);
      check("dz_hi", hi, 32'd5);
      check("dz_lo", lo, 32'd6);
      tick();
    end

    // Cancel ten cycles into a divide.
    force_lat = 40;
    drive_op(3'd2, 32'd1000, 32'd3);
    tick();
    idle_in();
    repeat (9) tick();
    cancel = 1'b1;
    @(negedge clk);
    check("cdiv_not_ready", op_ready, 1'b0);
    tick();
    cancel = 1'b0;
    @(negedge clk);
    check("cdiv_div_cancel", div_cancel, 1'b1);
    check("cdiv_busy", busy, 1'b0);
    check("cdiv_hi", hi, 32'd5);
    check("cdiv_lo", lo, 32'd6);
    tick();
    @(negedge clk);
    check("cdiv_cancel_once", div_cancel, 1'b0);
    tick();
    force_lat = 0;

    // Cancel in the multiply result cycle.
    drive_op(3'd1, 32'd7, 32'd9);
    tick();
    idle_in();
    repeat (MUL_LAT) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    @(negedge clk);
    check("cmul_hi", hi, 32'd5);
    check("cmul_lo", lo, 32'd6);
    check("cmul_busy", busy, 1'b0);
    tick();

    // Cancel alongside MTLO in IDLE.
    drive_op(3'd5, 32'hDEAD_BEEF, 32'd0);
    cancel = 1'b1;
    @(negedge clk);
    check("cmtlo_ready", op_ready, 1'b0);
    tick();
    cancel = 1'b0;
    idle_in();
    @(negedge clk);
    check("cmtlo_lo", lo, 32'd6);
    tick();

    // Back-to-back: MULTU then a held signed DIV.
    drive_op(3'd1, 32'h0001_0000, 32'h0001_0000);
    tick();
    t1 = cyc;
    drive_op(3'd2, 32'hFFFF_FF9C, 32'd7);  // -100 / 7
    ready_at = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (op_ready) begin
        ready_at = cyc;
        break;
      end
      tick();
    end
    check("b2b_ready_cycle", ready_at - t1, MUL_LAT + 1);
    check("b2b_mul_hi", hi, 32'd1);
    check("b2b_mul_lo", lo, 32'd0);
    tick();
    idle_in();
    done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check("b2b_div_done", done, 1'b1);
    check("b2b_div_hi", hi, 32'hFFFF_FFFE);
    check("b2b_div_lo", lo, 32'hFFFF_FFF2);
    tick();

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      resetn   = ($urandom_range(199, 0) != 0);
      cancel   = ($urandom_range(15, 0) == 0);
      op_valid = $urandom_range(1, 0);
      op_type  = 3'($urandom_range(7, 0));
      op_a     = $urandom;
      case ($urandom_range(3, 0))
        0:       op_b = 32'd0;
        1:       op_b = 32'($urandom_range(20, 1));
        default: op_b = $urandom;
      endcase
      tick();
    end

    resetn = 1'b1; cancel = 1'b0; idle_in();
    repeat (50) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hilo_ctrl.md
# hilo_ctrl

HI/LO multiply/divide controller for the execute/memory stages. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations and sequences the external pipelined multiplier and the external iterative divider. It owns the HI and LO architectural registers and asserts `busy` so the pipeline stalls MFHI/MFLO and further HI/LO operations. An exception flush aborts an in-flight operation without touching HI/LO.

## Interface
- `MUL_LAT`, 2: number of cycles from the `mul_start` cycle until `mul_result` is valid. Legal range 1..15.
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `op_valid` in 1: operation request.
- `op_type` in 3: operation code. 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 reserved (accepted, no effect).
- `op_a` / `op_b` in 32: rs / rt operands. MTHI/MTLO use `op_a`.
- `op_ready` out 1: `state==IDLE && !cancel`. The operation is accepted when `op_valid && op_ready`.
- `cancel` in 1: exception flush.
- `mul_start` out 1: one-cycle start pulse.
- `mul_signed` out 1: signed multiply.
- `mul_a` / `mul_b` out 32: registered operands.
- `mul_result` in 64: {hi, lo} product.
- `div_start` out 1: one-cycle start pulse.
- `div_signed` out 1: signed divide.
- `div_dividend` / `div_divisor` out 32: registered operands.
- `div_cancel` out 1: one-cycle abort pulse to the divider.
- `div_complete` in 1: divider result valid (single-cycle pulse).
- `div_quotient` / `div_remainder` in 32: divider results.
- `hi` / `lo` out 32: registered HI and LO.
- `busy` out 1: `state!=IDLE`.

## Operation
- States:
  - IDLE
  - MUL_RUN: `mul_start` cycle plus wait cycles
  - DIV_RUN: `div_start` cycle plus wait cycles
- IDLE, on acceptance:
  - MTHI / MTLO: `hi` / `lo` ← `op_a` at that edge; stay IDLE.
  - MULT / MULTU: latch operands and signedness; go to MUL_RUN with `cnt` ← 0.
  - DIV / DIVU with `op_b != 0`: latch operands; go to DIV_RUN.
  - DIV / DIVU with `op_b == 0`: HI/LO unchanged; stay IDLE; no `div_start` (divide-by-zero result is architecturally undefined; keep the old value).
- MUL_RUN:
  - `mul_start` = (`cnt==0`).
  - `cnt` increments each cycle.
  - In the cycle with `cnt==MUL_LAT`: {hi, lo} ← `mul_result`, then go to IDLE.
- DIV_RUN:
  - First cycle: `div_start`=1.
  - `div_complete` in the start cycle is ignored.
  - On `div_complete` in any later cycle: lo ← quotient, hi ← remainder, then go to IDLE.
  - No timeout.
- `cancel`:
  - Highest priority. In any busy cycle, including the result cycle, go to IDLE next edge with no HI/LO write.
  - If the state was DIV_RUN, `div_cancel` pulses for one cycle, in the cycle after `cancel`.
  - In IDLE, `cancel` blocks acceptance, and MTHI/MTLO are not written.
- Reserved `op_type`: accepted, no state change.
- `busy` and `op_ready` are never both 1.

## Timing
- Reset (`resetn`=0 at an edge) forces the next cycle to:
  - state IDLE, `cnt`=0
  - `hi`=`lo`=0
  - `mul_*` and `div_*` operand registers 0
  - `mul_start`=`div_start`=`div_cancel`=0
  - `busy`=0
  - `op_ready`=1 once `cancel`=0
- Reset mid-operation aborts with no HI/LO write and no `div_cancel`; the divider shares `resetn`.
- Acceptance at edge T:
  - MUL: `mul_start` in cycle T+1; result written at the end of cycle T+1+MUL_LAT; `busy` high for MUL_LAT+1 cycles; `op_ready` returns in cycle T+2+MUL_LAT.
  - DIV: `div_start` in cycle T+1; with `div_complete` in cycle C ≥ T+2, HI/LO update at the end of C and IDLE in C+1.
  - MTHI/MTLO: the new value is visible on `hi`/`lo` in cycle T+1; back-to-back acceptance every cycle is allowed.
- Start pulses are registered outputs: exactly one cycle, never repeated within one operation.
- A new operation may be accepted in the first IDLE cycle after completion (no bubble beyond that).

## Test plan
- Reset:
  - Drive `resetn`=0 for 2 cycles with `op_valid`=1, MTHI `op_a`=0x1234 → `hi`=`lo`=0, `busy`=0.
  - After release, the first accept writes `hi`=0x00001234 in the next cycle.
- MULT, MUL_LAT=2:
  - Operands `op_a`=0xFFFFFFFE (−2), `op_b`=3; model returns 0xFFFFFFFF_FFFFFFFA.
  - Expect `mul_start` exactly in T+1, `mul_signed`=1, `busy` for 3 cycles.
  - Expect `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA in cycle T+4.
- DIVU:
  - Operands 100 / 7; model asserts `div_complete` 33 cycles after `div_start`, plus a spurious `div_complete` in the start cycle.
  - Expect the spurious pulse ignored, `lo`=14, `hi`=2, and `op_ready` back the cycle after completion.
- Divide by zero:
  - Preload `hi`=5 and `lo`=6 via MTHI/MTLO on consecutive cycles, then DIV with `op_b`=0.
  - Expect no `div_start`, `busy` never 1, `hi`=5, `lo`=6.
- Cancel:
  - Assert `cancel` 10 cycles into a DIV → `div_cancel` for one cycle in the next cycle, IDLE, HI/LO unchanged.
  - Assert `cancel` in a MULT's result cycle → no write.
  - Assert `cancel` alongside MTLO in IDLE → `lo` unchanged.
- Back-to-back:
  - MULT, then DIV held on `op_valid` → DIV accepted in the first IDLE cycle.
  - Both results land in order; `op_ready` and `busy` are never both 1 (assertion).
